// File: rtl/router_pkg.sv
// Shared constants and sizing helpers for every router FIFO instance.
package router_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 10;
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_TH     = 2;

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width addressing depth entries (depth >= 2 guarantees >= 1 bit).
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for the router FIFO: one write port, one registered read
// port. No reset: the contents are meaningless until written.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = ptr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_q_r;

  // Write port: store the accepted word at the write address.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the addressed word before any same-edge write lands.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_q_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_q_r;

endmodule

// File: rtl/router_fifo.sv
// Router FIFO: pointers, occupancy, status flags and sticky error flags
// around a registered-read storage array. No fall-through; 1-cycle read.
module router_fifo
  import router_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int AF_TH  = DEPTH - DEF_AF_MARGIN,
  parameter  int AE_TH  = DEF_AE_TH,
  localparam int CW     = count_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  localparam int            PW       = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_TH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_TH);

  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              rd_valid_r;
  logic              rd_seen_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic [DATA_W-1:0] mem_q_s;

  // Wrap a pointer from the last entry back to zero without a modulo.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Status flags decoded straight from the count register.
  always_comb begin
    full         = (count_r == FULL_CNT);
    empty        = (count_r == {CW{1'b0}});
    almost_full  = (count_r >= AF_CNT);
    almost_empty = (count_r <= AE_CNT);
  end

  // Acceptance: flush wins over requests; a full FIFO takes a write only
  // when a read frees an entry on the same edge.
  always_comb begin
    rd_acc_s = 1'b0;
    wr_acc_s = 1'b0;
    if (!flush) begin
      rd_acc_s = rd_en && !empty;
      wr_acc_s = wr_en && (!full || rd_acc_s);
    end else begin
      rd_acc_s = 1'b0;
      wr_acc_s = 1'b0;
    end
  end

  router_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_r),
    .rd_data (mem_q_s)
  );

  // Pointer, occupancy, read-valid and sticky error state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      rd_valid_r  <= 1'b0;
      rd_seen_r   <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (rd_acc_s) begin
        rd_ptr_r  <= next_ptr(rd_ptr_r);
        rd_seen_r <= 1'b1;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      rd_valid_r <= rd_acc_s;
      if (wr_en && !wr_acc_s) begin
        overflow_r <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // The un-reset storage register is masked to zero until a word is popped,
  // so rd_data reads zero straight out of reset and holds across flush.
  always_comb begin
    if (rd_seen_r) begin
      rd_data = mem_q_s;
    end else begin
      rd_data = {DATA_W{1'b0}};
    end
  end

  assign rd_valid  = rd_valid_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo (DATA_W=32, DEPTH=10,
// AF_TH=8, AE_TH=2).
module tb_router_fifo;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  router_fifo #(
    .DATA_W (32),
    .DEPTH  (10),
    .AF_TH  (8),
    .AE_TH  (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    if (i == 3) return 32'h0000_0000;
    else        return 32'hA500_0000 | 32'(i);
  endfunction

  logic [31:0] q[$];
  logic [31:0] exp_rd;
  logic        do_rd;
  int          wi;

  initial begin
    reset_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 32'h0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_rdv", 32'(rd_valid), 32'd0);
    check("rst_rdata", rd_data, 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    #9 reset_n = 1'b1;

    // Simultaneous write+read on empty: no fall-through.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h55;
    step();
    check("nofall_rdv", 32'(rd_valid), 32'd0);
    check("nofall_count", 32'(count), 32'd1);
    check("nofall_unf", 32'(underflow), 32'd1);
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    check("lat_rdv", 32'(rd_valid), 32'd1);
    check("lat_rdata", rd_data, 32'h55);
    check("lat_empty", 32'(empty), 32'd1);
    rd_en = 1'b0;
    step();
    check("hold_rdv", 32'(rd_valid), 32'd0);
    check("hold_rdata", rd_data, 32'h55);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_unf", 32'(underflow), 32'd0);
    check("flush_rdata", rd_data, 32'h55);

    // Fill 0x1..0xA.
    wr_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wr_data = 32'(k);
      step();
      if (k == 2) check("ae_at2", 32'(almost_empty), 32'd1);
      if (k == 3) check("ae_at3", 32'(almost_empty), 32'd0);
      if (k == 7) check("af_at7", 32'(almost_full), 32'd0);
      if (k == 8) check("af_at8", 32'(almost_full), 32'd1);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd10);

    // Simultaneous read+write at full.
    rd_en = 1'b1; wr_data = 32'hFF;
    step();
    check("fullrw_count", 32'(count), 32'd10);
    check("fullrw_ovf", 32'(overflow), 32'd0);
    check("fullrw_rdata", rd_data, 32'h1);
    check("fullrw_rdv", 32'(rd_valid), 32'd1);

    // Write while full, no read: dropped.
    rd_en = 1'b0; wr_data = 32'hB;
    step();
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd10);

    // Drain: 0x2..0xA then 0xFF.
    wr_en = 1'b0; rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      exp_rd = (k < 9) ? 32'(k + 2) : 32'hFF;
      check("drain_rdata", rd_data, exp_rd);
      check("drain_rdv", 32'(rd_valid), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);
    step();
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_rdv", 32'(rd_valid), 32'd0);
    rd_en = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush2_ovf", 32'(overflow), 32'd0);

    // Streaming with interleaved reads, crossing the pointer wrap.
    wi = 0;
    q.delete();
    for (int c = 0; c < 80 && (wi < 25 || q.size() > 0); c++) begin
      wr_en   = (wi < 25);
      wr_data = word(wi);
      do_rd   = ((c % 2 == 1) || wi >= 25 || q.size() >= 8) && (q.size() > 0);
      rd_en   = do_rd;
      exp_rd  = do_rd ? q[0] : 32'h0;
      step();
      if (do_rd) begin
        void'(q.pop_front());
        check("stream_rdata", rd_data, exp_rd);
      end
      if (wr_en) begin
        q.push_back(word(wi));
        wi++;
      end
      check("stream_count", 32'(count), 32'(q.size()));
    end
    check("stream_done", 32'(wi), 32'd25);
    wr_en = 1'b0; rd_en = 1'b0;
    check("stream_ovf", 32'(overflow), 32'd0);
    check("stream_unf", 32'(underflow), 32'd0);

    // Flush with 5 entries and a concurrent write.
    wr_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wr_data = 32'h100 + 32'(k);
      step();
    end
    check("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1; wr_data = 32'h200;
    step();
    flush = 1'b0; wr_en = 1'b0;
    check("flushw_count", 32'(count), 32'd0);
    check("flushw_empty", 32'(empty), 32'd1);
    check("flushw_ovf", 32'(overflow), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_flush_unf", 32'(underflow), 32'd1);
    wr_en = 1'b1; wr_data = 32'h77;
    step();
    wr_en = 1'b0;
    check("pre_rst_count", 32'(count), 32'd1);

    // Asynchronous reset pulse between edges.
    #2 reset_n = 1'b0;
    #1;
    check("arst_unf", 32'(underflow), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_rdata", rd_data, 32'h0);
    #1 reset_n = 1'b1;
    wr_en = 1'b1; wr_data = 32'h99;
    step();
    wr_en = 1'b0;
    check("post_rst_count", 32'(count), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_rst_rdata", rd_data, 32'h99);
    check("post_rst_rdv", 32'(rd_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 10, number of storage entries; any integer >= 2, power of two not required.
REQ-003 Parameter AF_TH, default DEPTH-2, almost_full asserts when count >= AF_TH.
REQ-004 Parameter AE_TH, default 2, almost_empty asserts when count <= AE_TH.
REQ-005 Port list (name, direction, width, meaning):
  clock  in  1  single clock, all state on rising edge
  reset_n  in  1  asynchronous active-low reset
  flush  in  1  synchronous clear of contents and error flags
  wr_en  in  1  write request
  wr_data  in  DATA_W  write word
  rd_en  in  1  read request
  rd_data  out  DATA_W  registered read word
  rd_valid  out  1  rd_data carries a newly popped word this cycle
  full  out  1  count == DEPTH
  empty  out  1  count == 0
  almost_full  out  1  count >= AF_TH
  almost_empty  out  1  count <= AE_TH
  count  out  CW  occupancy, CW = clog2(DEPTH+1)
  overflow  out  1  sticky: write dropped
  underflow  out  1  sticky: read dropped

Function
REQ-006 Write accepted when wr_en && (!full || read accepted same cycle); accepted word stored at wr_ptr.
REQ-007 Read accepted when rd_en && !empty; no fall-through: a word written in cycle N is readable no earlier than cycle N+1.
REQ-008 Read latency 1 cycle: word popped at edge N appears on rd_data with rd_valid=1 after edge N, held until the next accepted read; rd_valid is 1 only in the cycle after an accepted read.
REQ-009 Pointers advance by 1 on acceptance and wrap DEPTH-1 -> 0; no modulo by non-constant.
REQ-010 count: +1 write only, -1 read only, unchanged for simultaneous accepted read and write, including at full (DEPTH) and at the read-side boundary.
REQ-011 full, empty, almost_full, almost_empty decoded combinationally from the count register; flags and count never disagree.
REQ-012 overflow sets on wr_en when the write is not accepted; underflow sets on rd_en && empty; both remain set until flush or reset.
REQ-013 Rejected requests change no pointer, count, or data.
REQ-014 flush=1 at an edge: pointers, count, rd_valid, overflow, underflow -> 0; same-cycle wr_en/rd_en ignored and do not set error flags; rd_data holds its value; storage array not cleared.
REQ-015 A stored all-zero word is legal data and is read normally.

Reset
REQ-016 reset_n low asynchronously forces wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0 (for AF_TH >= 1).
REQ-017 Storage array is not reset; reset asserted mid-operation discards all contents and takes effect without a clock edge.
REQ-018 Deassertion is synchronised externally; first accepted write can occur at the first edge after release.

Structure
REQ-019 Shared package router_pkg holds the default DATA_W, DEPTH, and threshold constants and the count-width function used by all router FIFO instances.
REQ-020 Storage is a sub-module router_fifo_mem (one write port, one registered read port, no reset); pointer, count, flag, and error logic reside in router_fifo.
REQ-021 Simulation $display statements are not part of the RTL.

Verification (DATA_W=32, DEPTH=10, AF_TH=8, AE_TH=2)
REQ-022 Write 10 words 0x1..0xA -> full=1 and count=10 after the 10th edge; 11th write 0xB -> overflow=1 and count stays 10; reading 10 returns 0x1..0xA in order, then empty=1.
REQ-023 On reset, wr_en=1 and rd_en=1 in the same cycle with 0x55 -> no rd_valid, count=1; next-cycle read -> rd_data=0x55 with rd_valid=1 one cycle later.
REQ-024 At full, simultaneous read/write of 0xFF -> count stays 10, overflow stays 0, oldest word popped, 0xFF read last.
REQ-025 Stream 25 words with interleaved reads -> pointers wrap past 9 -> 0 with no loss or reorder; word 0x00000000 is included and returned.
REQ-026 With 5 entries, flush with wr_en=1 -> count=0, empty=1, overflow=0; then rd_en -> underflow=1; then reset_n pulsed low mid-cycle -> all flags cleared immediately.
